// File: rtl/datapath_pkg.sv
// Shared encodings for the register-file/ALU sequencing controller.
// Opcodes, 5-bit state codes and writeback-mux selects.
package datapath_pkg;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_MOVE = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;

  localparam logic [1:0] WB_IMM = 2'b00;
  localparam logic [1:0] WB_RFA = 2'b01;
  localparam logic [1:0] WB_ALU = 2'b10;

  typedef enum logic [4:0] {
    ST_RESET  = 5'b00000,
    ST_WAIT   = 5'b00001,
    ST_DECODE = 5'b00010,
    ST_ADD1   = 5'b00011,
    ST_ADD2   = 5'b00100,
    ST_ADD3   = 5'b00101,
    ST_LD     = 5'b00110,
    ST_MV     = 5'b00111,
    ST_XOR1   = 5'b01000,
    ST_XOR2   = 5'b01001,
    ST_XOR3   = 5'b01010
  } state_t;

endpackage

// File: rtl/datapath_seq_ctrl_if.sv
// Instruction valid/ready handshake into the controller.
// Master presents words; slave is the controller.
interface datapath_seq_ctrl_if #(
  parameter int IW = 25
);
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready;

  modport master (
    output instr,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  instr,
    input  instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/datapath_seq_ctrl_fields.sv
// Splits the instruction register into its fields.
// Opcode sits in the top three bits; dst/srcA/srcB follow.
module datapath_seq_ctrl_fields #(
  parameter int IW   = 25,
  parameter int RAW  = 4,
  parameter int IMMW = 10
) (
  input  logic [IW-1:0]   ir,
  output logic [2:0]      opcode,
  output logic [RAW-1:0]  dst,
  output logic [RAW-1:0]  src_a,
  output logic [RAW-1:0]  src_b,
  output logic [IMMW-1:0] imm
);
  assign opcode = ir[IW-1 -: 3];
  assign dst    = ir[IW-4 -: RAW];
  assign src_a  = ir[IW-4-RAW -: RAW];
  assign src_b  = ir[IW-4-2*RAW -: RAW];
  assign imm    = ir[IMMW-1:0];
endmodule

// File: rtl/datapath_seq_ctrl.sv
// One-instruction-at-a-time sequencer for the RF/ALU datapath.
// All controls decode from registered state and ir.
module datapath_seq_ctrl
  import datapath_pkg::*;
#(
  parameter int IW   = 25,
  parameter int RAW  = 4,
  parameter int IMMW = 10
) (
  input  logic                clk,
  input  logic                rst,
  datapath_seq_ctrl_if.slave  bus,
  input  logic                stall,
  output logic [RAW-1:0]      rf_raddr_a,
  output logic [RAW-1:0]      rf_raddr_b,
  output logic [RAW-1:0]      rf_waddr,
  output logic                rf_we,
  output logic [IMMW-1:0]     imm,
  output logic                opa_ld,
  output logic                opb_ld,
  output logic                alu_op,
  output logic [1:0]          wb_sel,
  output logic                done,
  output logic                illegal,
  output logic [4:0]          state
);
  state_t          state_q, state_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic [2:0]      opcode;
  logic            ready;
  logic            exec;
  logic            hold;
  logic            we_r, opa_r, opb_r;
  logic            done_r, ill_r;

  datapath_seq_ctrl_fields #(
    .IW   (IW),
    .RAW  (RAW),
    .IMMW (IMMW)
  ) u_fields (
    .ir     (ir_q),
    .opcode (opcode),
    .dst    (rf_waddr),
    .src_a  (rf_raddr_a),
    .src_b  (rf_raddr_b),
    .imm    (imm)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RESET;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    ready   = 1'b0;
    exec    = 1'b0;
    we_r    = 1'b0;
    opa_r   = 1'b0;
    opb_r   = 1'b0;
    done_r  = 1'b0;
    ill_r   = 1'b0;
    alu_op  = 1'b0;
    wb_sel  = WB_IMM;
    unique case (state_q)
      ST_RESET: state_d = ST_WAIT;
      ST_WAIT: begin
        ready = 1'b1;
        if (bus.instr_valid) begin
          ir_d    = bus.instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_LOAD: state_d = ST_LD;
          OP_MOVE: state_d = ST_MV;
          OP_ADD:  state_d = ST_ADD1;
          OP_XOR:  state_d = ST_XOR1;
          default: begin
            done_r  = 1'b1;
            ill_r   = 1'b1;
            state_d = ST_WAIT;
          end
        endcase
      end
      ST_LD: begin
        exec   = 1'b1;
        we_r   = 1'b1;
        done_r = 1'b1;
        if (!stall) state_d = ST_WAIT;
      end
      ST_MV: begin
        exec   = 1'b1;
        we_r   = 1'b1;
        done_r = 1'b1;
        wb_sel = WB_RFA;
        if (!stall) state_d = ST_WAIT;
      end
      ST_ADD1, ST_XOR1: begin
        exec  = 1'b1;
        opa_r = 1'b1;
        if (!stall)
          state_d = (state_q == ST_ADD1) ?
                    ST_ADD2 : ST_XOR2;
      end
      ST_ADD2, ST_XOR2: begin
        exec  = 1'b1;
        opb_r = 1'b1;
        if (!stall)
          state_d = (state_q == ST_ADD2) ?
                    ST_ADD3 : ST_XOR3;
      end
      ST_ADD3, ST_XOR3: begin
        exec   = 1'b1;
        we_r   = 1'b1;
        done_r = 1'b1;
        wb_sel = WB_ALU;
        alu_op = (state_q == ST_XOR3);
        if (!stall) state_d = ST_WAIT;
      end
      default: state_d = ST_RESET;
    endcase
  end

  // stall only gates strobes in execute states
  assign hold    = exec & stall;
  assign rf_we   = we_r   & ~hold;
  assign opa_ld  = opa_r  & ~hold;
  assign opb_ld  = opb_r  & ~hold;
  assign done    = done_r & ~hold;
  assign illegal = ill_r;

  assign bus.instr_ready = ready;
  assign state           = state_q;
endmodule
